// File: rtl/adpll_pkg.sv
// Shared constants and helpers for the ADPLL loop controller.
package adpll_pkg;

   localparam int unsigned ADPLL_FSEL_W = 4;

   // Encoding is visible on state_o, so the values are fixed.
   typedef enum logic [2:0] {
      StIdle    = 3'd0,
      StStart   = 3'd1,
      StCSettle = 3'd2,
      StCSample = 3'd3,
      StFSettle = 3'd4,
      StFSample = 3'd5,
      StLocked  = 3'd6
   } adpll_state_e;

   // Number of bits needed to hold values 0..value-1.
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned result;
      result = 0;
      while ((32'd1 << result) < value) result++;
      return result;
   endfunction

endpackage

// File: rtl/adpll_window_counter.sv
// PD synchronizer plus settle/sample phase counter and ups accumulator.
module adpll_window_counter import adpll_pkg::*; #(
   parameter int unsigned WINDOW = 64,
   parameter int unsigned SETTLE = 16,
   localparam int unsigned UPS_W = clog2(WINDOW) + 1
) (
   input  logic             fpga_clk_i,
   input  logic             rst_n_i,
   input  logic             clear_i,
   input  logic             run_i,
   input  logic             pd_i,
   output logic             settle_done_o,
   output logic             window_done_o,
   output logic [UPS_W-1:0] ups_o
);

   localparam int unsigned PERIOD = SETTLE + WINDOW;
   localparam int unsigned PH_W   = clog2(PERIOD);

   logic             pd_meta_q, pd_sync_q;
   logic [PH_W-1:0]  phase_q, phase_d;
   logic [UPS_W-1:0] ups_q, ups_d;
   logic             sampling;

   // Two-flop synchronizer for the asynchronous PD output.
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         pd_meta_q <= 1'b0;
         pd_sync_q <= 1'b0;
      end else begin
         pd_meta_q <= pd_i;
         pd_sync_q <= pd_meta_q;
      end
   end

   // Phase walks settle then sample; ups_o already includes the current sample.
   always_comb begin
      sampling      = (phase_q >= PH_W'(SETTLE));
      settle_done_o = run_i && (phase_q == PH_W'(SETTLE - 1));
      window_done_o = run_i && (phase_q == PH_W'(PERIOD - 1));
      ups_o         = ups_q + {{(UPS_W-1){1'b0}}, (sampling && pd_sync_q)};
      phase_d       = phase_q;
      ups_d         = ups_q;
      if (clear_i) begin
         phase_d = '0;
         ups_d   = '0;
      end else if (run_i) begin
         if (window_done_o) begin
            phase_d = '0;
            ups_d   = '0;
         end else begin
            phase_d = phase_q + 1'b1;
            ups_d   = ups_o;
         end
      end
   end

   // Counter state registers.
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         phase_q <= '0;
         ups_q   <= '0;
      end else begin
         phase_q <= phase_d;
         ups_q   <= ups_d;
      end
   end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// ADPLL loop controller: binary-search coarse acquisition, then bang-bang
// fine tracking with lock / loss-of-lock detection.
module adpll_loop_ctrl import adpll_pkg::*; #(
   parameter int unsigned FSEL_W     = ADPLL_FSEL_W,
   parameter int unsigned WINDOW     = 64,
   parameter int unsigned SETTLE     = 16,
   parameter int unsigned DEADBAND   = 4,
   parameter int unsigned LOCK_COUNT = 8,
   parameter int unsigned LOSS_COUNT = 2
) (
   input  logic              fpga_clk_i,
   input  logic              rst_n_i,
   input  logic              enable_i,
   input  logic              restart_i,
   input  logic              pd_i,
   output logic [FSEL_W-1:0] freq_sel_o,
   output logic              ro_enable_o,
   output logic              pd_enable_o,
   output logic              locked_o,
   output logic [2:0]        state_o
);

   localparam int unsigned UPS_W = clog2(WINDOW) + 1;
   localparam int unsigned LCK_W = clog2(LOCK_COUNT + 1);
   localparam int unsigned LOS_W = clog2(LOSS_COUNT + 1);
   localparam logic [UPS_W-1:0]  HalfWin = UPS_W'(WINDOW / 2);
   localparam logic [UPS_W-1:0]  UpThr   = UPS_W'(WINDOW / 2 + DEADBAND);
   localparam logic [UPS_W-1:0]  DnThr   = UPS_W'(WINDOW / 2 - DEADBAND);
   localparam logic [FSEL_W-1:0] FselMax = '1;
   localparam logic [FSEL_W-1:0] FselMsb = {1'b1, {(FSEL_W-1){1'b0}}};

   adpll_state_e      state_q, state_d;
   logic [FSEL_W-1:0] freq_q, freq_d, trial_q, trial_d, freq_fine;
   logic [LCK_W-1:0]  lock_cnt_q, lock_cnt_d;
   logic [LOS_W-1:0]  loss_cnt_q, loss_cnt_d;
   logic              pd_en_q, pd_en_d;
   logic              settle_done, window_done, clear, run;
   logic [UPS_W-1:0]  ups;
   logic              ups_high, ups_low, fine_hold;

   adpll_window_counter #(
      .WINDOW (WINDOW),
      .SETTLE (SETTLE)
   ) u_window (
      .fpga_clk_i    (fpga_clk_i),
      .rst_n_i       (rst_n_i),
      .clear_i       (clear),
      .run_i         (run),
      .pd_i          (pd_i),
      .settle_done_o (settle_done),
      .window_done_o (window_done),
      .ups_o         (ups)
   );

   // Counter restarts whenever the loop (re)starts; it only runs once past START.
   always_comb begin
      clear = (state_d == StIdle) || (state_d == StStart);
      run   = (state_q != StIdle) && (state_q != StStart);
   end

   // Fine-mode decision: saturating step outside the dead band, hold inside it.
   always_comb begin
      ups_high  = ups > UpThr;
      ups_low   = ups < DnThr;
      fine_hold = !ups_high && !ups_low;
      freq_fine = freq_q;
      if (ups_high && (freq_q != FselMax)) freq_fine = freq_q + 1'b1;
      if (ups_low && (freq_q != '0))       freq_fine = freq_q - 1'b1;
   end

   // State register.
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state_q <= StIdle;
      else          state_q <= state_d;
   end

   // Next-state logic; disable beats restart, restart beats everything else.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    state_d = StStart;
         StStart:   state_d = StCSettle;
         StCSettle: if (settle_done) state_d = StCSample;
         StCSample: if (window_done) state_d = trial_q[0] ? StFSettle : StCSettle;
         StFSettle: if (settle_done) state_d = StFSample;
         StFSample: begin
            if (window_done) begin
               state_d = (fine_hold && (lock_cnt_q == LCK_W'(LOCK_COUNT - 1))) ?
                         StLocked : StFSettle;
            end
         end
         StLocked: begin
            if (window_done && !fine_hold && (loss_cnt_q == LOS_W'(LOSS_COUNT - 1))) begin
               state_d = StFSettle;
            end
         end
         default:   state_d = StIdle;
      endcase
      if (restart_i && (state_q != StIdle)) state_d = StStart;
      if (!enable_i)                        state_d = StIdle;
   end

   // Datapath next-state: freq word, trial bit, lock and loss counters.
   always_comb begin
      freq_d     = freq_q;
      trial_d    = trial_q;
      lock_cnt_d = lock_cnt_q;
      loss_cnt_d = loss_cnt_q;
      pd_en_d    = (state_q != StIdle) && (state_d != StIdle);
      if (state_d == StIdle) begin
         freq_d     = '0;
         trial_d    = '0;
         lock_cnt_d = '0;
         loss_cnt_d = '0;
      end else if (state_d == StStart) begin
         freq_d     = FselMsb;
         trial_d    = FselMsb;
         lock_cnt_d = '0;
         loss_cnt_d = '0;
      end else if (window_done) begin
         case (state_q)
            StCSample: begin
               // Keep or drop the trial bit, then try the next lower one.
               freq_d  = (ups > HalfWin) ? freq_q : (freq_q & ~trial_q);
               freq_d  = freq_d | (trial_q >> 1);
               trial_d = trial_q >> 1;
            end
            StFSample: begin
               freq_d     = freq_fine;
               lock_cnt_d = fine_hold ? (lock_cnt_q + 1'b1) : '0;
               loss_cnt_d = '0;
            end
            StLocked: begin
               freq_d     = freq_fine;
               loss_cnt_d = fine_hold ? '0 : (loss_cnt_q + 1'b1);
               if (state_d == StFSettle) begin
                  lock_cnt_d = '0;
                  loss_cnt_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Datapath registers.
   always_ff @(posedge fpga_clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         freq_q     <= '0;
         trial_q    <= '0;
         lock_cnt_q <= '0;
         loss_cnt_q <= '0;
         pd_en_q    <= 1'b0;
      end else begin
         freq_q     <= freq_d;
         trial_q    <= trial_d;
         lock_cnt_q <= lock_cnt_d;
         loss_cnt_q <= loss_cnt_d;
         pd_en_q    <= pd_en_d;
      end
   end

   // Outputs decoded from state; pd enable lags oscillator enable by one cycle.
   always_comb begin
      freq_sel_o  = freq_q;
      ro_enable_o = (state_q != StIdle);
      pd_enable_o = pd_en_q;
      locked_o    = (state_q == StLocked);
      state_o     = state_q;
   end

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// Directed bench for adpll_loop_ctrl with a cycle-level behavioural model.
module tb_adpll_loop_ctrl;

   localparam int FSEL_W     = 4;
   localparam int WINDOW     = 64;
   localparam int SETTLE     = 16;
   localparam int DEADBAND   = 4;
   localparam int LOCK_COUNT = 8;
   localparam int LOSS_COUNT = 2;
   localparam int PERIOD     = SETTLE + WINDOW;
   localparam int FMAX       = (1 << FSEL_W) - 1;
   localparam int LOG_N      = 8192;

   logic              fpga_clk = 1'b0;
   logic              rst_n    = 1'b0;
   logic              enable   = 1'b0;
   logic              restart  = 1'b0;
   logic              pd       = 1'b0;
   logic [FSEL_W-1:0] freq_sel;
   logic              ro_en, pd_en, locked;
   logic [2:0]        state;

   int n_checks = 0;
   int n_fail   = 0;

   // Oscillator environment.
   int target     = 11;
   int force_mode = 0;  // 0 model, 1 force high, 2 force low
   bit tgl        = 1'b0;

   adpll_loop_ctrl #(
      .FSEL_W     (FSEL_W),
      .WINDOW     (WINDOW),
      .SETTLE     (SETTLE),
      .DEADBAND   (DEADBAND),
      .LOCK_COUNT (LOCK_COUNT),
      .LOSS_COUNT (LOSS_COUNT)
   ) dut (
      .fpga_clk_i  (fpga_clk),
      .rst_n_i     (rst_n),
      .enable_i    (enable),
      .restart_i   (restart),
      .pd_i        (pd),
      .freq_sel_o  (freq_sel),
      .ro_enable_o (ro_en),
      .pd_enable_o (pd_en),
      .locked_o    (locked),
      .state_o     (state)
   );

   always #5 fpga_clk = ~fpga_clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge fpga_clk);
   endtask

   // PD behaviour: high when too slow, low when too fast, toggling when on target.
   always @(negedge fpga_clk) begin
      tgl = ~tgl;
      if (force_mode == 1)               pd = 1'b1;
      else if (force_mode == 2)          pd = 1'b0;
      else if (int'(freq_sel) < target)  pd = 1'b1;
      else if (int'(freq_sel) > target)  pd = 1'b0;
      else                               pd = tgl;
   end

   // ---------------- behavioural model ----------------
   // mode: 0 idle, 1 start, 2 coarse, 3 fine, 4 locked
   int m_mode = 0, m_freq = 0, m_bit = 0, m_lock = 0, m_loss = 0;
   int m_wstart = 0, m_state = 0, m_pden = 0, n_edge = 0;
   bit pd_log [LOG_N];

   task automatic m_clear();
      m_mode = 0; m_freq = 0; m_bit = 0; m_lock = 0; m_loss = 0; m_pden = 0; m_state = 0;
   endtask

   task automatic m_step(input int n);
      int  ups;
      bit  hold;
      bit  was_active;
      was_active = (m_mode != 0);
      if (!enable) begin
         m_clear();
      end else if (m_mode == 0 || restart) begin
         m_mode = 1; m_bit = FSEL_W - 1; m_freq = 1 << m_bit; m_lock = 0; m_loss = 0;
      end else if (m_mode == 1) begin
         m_mode = 2; m_wstart = n;
      end else if (n - m_wstart == PERIOD) begin
         // PD samples seen by the decision: shifted by the two-flop synchronizer.
         ups = 0;
         for (int k = 0; k < WINDOW; k++) ups += pd_log[(m_wstart + SETTLE - 1 + k) % LOG_N];
         m_wstart = n;
         if (m_mode == 2) begin
            if (ups <= WINDOW / 2) m_freq -= (1 << m_bit);
            if (m_bit == 0) m_mode = 3;
            else begin
               m_bit--;
               m_freq += (1 << m_bit);
            end
         end else begin
            hold = 1'b0;
            if (ups > WINDOW / 2 + DEADBAND) begin
               if (m_freq < FMAX) m_freq++;
            end else if (ups < WINDOW / 2 - DEADBAND) begin
               if (m_freq > 0) m_freq--;
            end else hold = 1'b1;
            if (m_mode == 3) begin
               m_lock = hold ? m_lock + 1 : 0;
               if (m_lock == LOCK_COUNT) begin m_mode = 4; m_loss = 0; end
            end else begin
               m_loss = hold ? 0 : m_loss + 1;
               if (m_loss == LOSS_COUNT) begin m_mode = 3; m_lock = 0; m_loss = 0; end
            end
         end
      end
      m_pden = (was_active && m_mode != 0) ? 1 : 0;
      case (m_mode)
         0: m_state = 0;
         1: m_state = 1;
         2: m_state = (n - m_wstart < SETTLE) ? 2 : 3;
         3: m_state = (n - m_wstart < SETTLE) ? 4 : 5;
         default: m_state = 6;
      endcase
   endtask

   always @(posedge fpga_clk or negedge rst_n) begin
      if (!rst_n) begin
         m_clear();
      end else begin
         pd_log[n_edge % LOG_N] = pd;
         m_step(n_edge);
         n_edge++;
      end
   end

   // Cycle-by-cycle comparison against the model.
   always @(posedge fpga_clk) begin
      #2;
      check("cyc_freq_sel", int'(freq_sel), m_freq);
      check("cyc_state", int'(state), m_state);
      check("cyc_ro_enable", int'(ro_en), (m_mode != 0) ? 1 : 0);
      check("cyc_pd_enable", int'(pd_en), m_pden);
      check("cyc_locked", int'(locked), (m_mode == 4) ? 1 : 0);
   end

   // ---------------- directed stimulus ----------------
   initial begin
      cycles(3);
      check("rst_state", int'(state), 0);
      check("rst_freq", int'(freq_sel), 0);
      check("rst_ro_en", int'(ro_en), 0);
      check("rst_pd_en", int'(pd_en), 0);
      check("rst_locked", int'(locked), 0);
      rst_n = 1'b1;
      cycles(2);
      check("idle_without_enable", int'(state), 0);

      // T=11: trials 8,12,10,11 -> coarse 10, fine 11, lock.
      target = 11;
      enable = 1'b1;
      cycles(1);
      check("start_state", int'(state), 1);
      check("start_freq", int'(freq_sel), 8);
      check("start_ro_en", int'(ro_en), 1);
      check("start_pd_en", int'(pd_en), 0);
      cycles(1);
      check("csettle_state", int'(state), 2);
      check("csettle_pd_en", int'(pd_en), 1);
      cycles(80);
      check("t11_trial2", int'(freq_sel), 12);
      cycles(80);
      check("t11_trial3", int'(freq_sel), 10);
      cycles(80);
      check("t11_trial4", int'(freq_sel), 11);
      cycles(80);
      check("t11_coarse_freq", int'(freq_sel), 10);
      check("t11_coarse_state", int'(state), 4);
      cycles(720);
      check("t11_locked", int'(locked), 1);
      check("t11_lock_freq", int'(freq_sel), 11);

      // Target moves to 13 while locked: two corrections drop lock, then relock.
      target = 13;
      cycles(80);
      check("t13_first_corr_freq", int'(freq_sel), 12);
      check("t13_first_corr_locked", int'(locked), 1);
      cycles(80);
      check("t13_unlock", int'(locked), 0);
      check("t13_unlock_freq", int'(freq_sel), 13);
      check("t13_unlock_state", int'(state), 4);
      cycles(640);
      check("t13_relock", int'(locked), 1);

      // Restart in LOCKED, then async reset mid C_SAMPLE.
      restart = 1'b1;
      cycles(1);
      restart = 1'b0;
      check("restart_state", int'(state), 1);
      check("restart_freq", int'(freq_sel), 8);
      check("restart_locked", int'(locked), 0);
      cycles(40);
      check("csample_state", int'(state), 3);
      #3 rst_n = 1'b0;
      #1;
      check("async_rst_state", int'(state), 0);
      check("async_rst_freq", int'(freq_sel), 0);
      check("async_rst_ro_en", int'(ro_en), 0);
      check("async_rst_pd_en", int'(pd_en), 0);
      @(negedge fpga_clk);

      // T=15: coarse 14, fine 15, forced-high PD saturates and drops lock.
      target = 15;
      rst_n  = 1'b1;
      cycles(1);
      check("t15_start_state", int'(state), 1);
      cycles(321);
      check("t15_coarse_freq", int'(freq_sel), 14);
      cycles(720);
      check("t15_locked", int'(locked), 1);
      check("t15_lock_freq", int'(freq_sel), 15);
      force_mode = 1;
      cycles(80);
      check("t15_sat_freq", int'(freq_sel), 15);
      cycles(80);
      check("t15_unlock", int'(locked), 0);
      check("t15_nowrap_freq", int'(freq_sel), 15);
      force_mode = 0;
      cycles(40);
      check("fsample_state", int'(state), 5);
      enable = 1'b0;
      cycles(1);
      check("disable_state", int'(state), 0);
      check("disable_freq", int'(freq_sel), 0);
      check("disable_ro_en", int'(ro_en), 0);
      check("disable_pd_en", int'(pd_en), 0);

      // T=0: coarse 0, holds and locks; forced-low PD does not wrap.
      target = 0;
      enable = 1'b1;
      cycles(1);
      cycles(321);
      check("t0_coarse_freq", int'(freq_sel), 0);
      check("t0_coarse_state", int'(state), 4);
      cycles(640);
      check("t0_locked", int'(locked), 1);
      force_mode = 2;
      cycles(160);
      check("t0_unlock", int'(locked), 0);
      check("t0_nowrap_freq", int'(freq_sel), 0);

      // Disable together with restart: disable wins.
      enable  = 1'b0;
      restart = 1'b1;
      cycles(1);
      check("disable_beats_restart", int'(state), 0);
      restart = 1'b0;
      force_mode = 0;
      cycles(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/adpll_loop_ctrl.md
Name: adpll_loop_ctrl

Overview:
- Loop controller for the ring-oscillator ADPLL: closes the loop between the bang-bang phase detector output and the ring oscillator frequency-select word.
- Sequences oscillator/PD enables, runs a binary-search coarse acquisition, then bang-bang fine tracking with lock detection.
- Sits between the BangBangPD output and the RingOsc freq_sel input, clocked from the fast fabric clock that also drives the reference phase accumulator.

Parameters:
- FSEL_W, 4, width of the ring oscillator frequency-select word.
- WINDOW, 64, PD samples per decision window (power of 2, >=8).
- SETTLE, 16, cycles waited after every freq_sel change before sampling.
- DEADBAND, 4, half-width of the hold band around WINDOW/2 in fine mode.
- LOCK_COUNT, 8, consecutive hold windows needed to declare lock.
- LOSS_COUNT, 2, consecutive correcting windows in LOCKED that drop lock.

Ports:
- fpga_clk_i  in  1  fabric clock; all logic on its rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  loop enable; low forces IDLE from any state.
- restart_i  in  1  single-cycle pulse; re-runs coarse acquisition.
- pd_i  in  1  raw PD output (asynchronous; 1 = reference leads, oscillator too slow).
- freq_sel_o  out  FSEL_W  frequency-select word to ring oscillator.
- ro_enable_o  out  1  ring oscillator enable.
- pd_enable_o  out  1  phase detector enable.
- locked_o  out  1  loop locked.
- state_o  out  3  current state encoding, for LEDs/debug.

Behaviour:
- Reset (rst_n_i low, asynchronous): state IDLE, freq_sel_o=0, all enables 0, locked_o=0, all counters 0.
- pd_i passes through a 2-flop synchronizer; window counting uses the synchronized value, adding 2 cycles of latency.
- States: IDLE=0, START=1, C_SETTLE=2, C_SAMPLE=3, F_SETTLE=4, F_SAMPLE=5, LOCKED=6.
- IDLE: all outputs 0. If enable_i=1, go to START.
- START, one cycle: ro_enable_o=1; freq_sel_o=0 with MSB set (trial bit = MSB); go to C_SETTLE.
- ro_enable_o and pd_enable_o are 1 in every state except IDLE. pd_enable_o rises one cycle after ro_enable_o.
- C_SETTLE: count SETTLE cycles, then go to C_SAMPLE. The ups counter clears on entry.
- C_SAMPLE: count WINDOW cycles, accumulating synchronized pd_i highs in a counter of width log2(WINDOW)+1.
  - At window end: keep the trial bit if ups > WINDOW/2, else clear it.
  - If the trial bit was not the LSB, set the next lower bit and go to C_SETTLE.
  - If it was the LSB, go to F_SETTLE.
- F_SETTLE / F_SAMPLE: same timing as coarse. At window end:
  - ups > WINDOW/2+DEADBAND: freq_sel+1, saturating at all-ones; lock counter cleared.
  - ups < WINDOW/2-DEADBAND: freq_sel-1, saturating at 0; lock counter cleared.
  - Otherwise: hold, lock counter +1.
  - A saturated step counts as a correction, not a hold.
  - Lock counter reaches LOCK_COUNT: go to LOCKED, locked_o=1 on that clock edge. Otherwise go to F_SETTLE.
- LOCKED: keeps running the settle/sample cycle with the same correction rule; locked_o stays 1.
  - A hold window clears the loss counter. A correction increments it.
  - Loss counter reaches LOSS_COUNT: locked_o=0, lock counter cleared, go to F_SETTLE.
- enable_i low in any state: next cycle is IDLE with reset values. Mid-window counts are discarded.
- restart_i in any non-IDLE state: locked_o=0, counters cleared, behaves as START next cycle.
- enable_i low together with restart_i: enable_i wins.
- Decision timing: every decision occurs exactly SETTLE+WINDOW cycles after the previous one. Full coarse acquisition takes 1 + FSEL_W*(SETTLE+WINDOW) cycles.

Decomposition:
- Package adpll_pkg: state encoding constants, the ADPLL_FSEL_W default, and a clog2 function for counter widths.
- One natural sub-module: adpll_window_counter. It contains the synchronizer, the settle/sample cycle counter, and the ups counter. It outputs window_done and ups; the FSM in adpll_loop_ctrl consumes them.

Test Plan:
- PD model for all tests: pd_i=1 if freq_sel<T, 0 if freq_sel>T, toggles every cycle if equal.
- T=11, enable_i 0→1: freq_sel trials 8,12,10,11 → coarse result 10 at cycle 1+4*80=321 → fine steps to 11 → locked_o=1 after 8 hold windows.
- T=15: coarse yields 14, fine reaches 15. At 15 ups=32, so it holds and locks. Force pd_i=1 in LOCKED: saturates at 15, no wrap; locked_o drops after 2 windows.
- T=0: coarse yields 0, fine holds at 0 (toggle gives 32 ups) → lock. Force pd_i=0: stays 0, no wrap to 15.
- In LOCKED with T=11, change T to 13: 2 correction windows → locked_o=0 → freq_sel reaches 13 → relock.
- Async reset mid C_SAMPLE, and separately enable_i=0 mid F_SAMPLE: outputs go to reset values (asynchronously for reset, next cycle for enable). restart_i pulse in LOCKED: locked_o=0 next cycle, coarse reruns from MSB trial 8.
